rom_port_arbiter: RTL and testbench

// - Shares the single combinational read port of the instruction ROM between the fetch stage (I) and the memory stage (D, constant/.rodata loads).
// - Sits between the pipeline and the ROM: selects one requester per cycle, drives the ROM address, registers the returned word, delivers it one cycle later.
// - Data-side priority with a starvation guard so fetch always makes progress; supports fetch flush on redirect.

---
 rtl/rom_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_rom_port_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Arbitrates the single combinational instruction-ROM read port between fetch (I) and data (D).
// Optional statistics counters are enabled with `define ROM_ARB_STATS_EN.

`ifndef WORD_ADDRESS_SIZE
`define WORD_ADDRESS_SIZE 2
`endif

module rom_port_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  output logic              if_resp_misaligned,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              d_resp_misaligned,
  input  logic              flush,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_if_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_conflicts
`endif
);

  localparam int unsigned SW  = 4;
  localparam int unsigned WAS = `WORD_ADDRESS_SIZE;

  generate
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
      $error("rom_port_arbiter: MAX_WAIT must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  owner_e            owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [DATA_W-1:0] if_data_q, if_data_d, d_data_q, d_data_d;
  logic              if_mis_q, if_mis_d, d_mis_q, d_mis_d;
  logic              grant_i, grant_d, word_mis;
  logic [DATA_W-1:0] word;

  // Grant: data side wins conflicts until fetch has been refused MAX_WAIT times
  always_comb begin
    grant_i     = !reset && if_valid && !flush &&
                  (!d_valid || starve_q >= SW'(MAX_WAIT));
    grant_d     = !reset && d_valid && !grant_i;
    rom_address = grant_d ? d_addr : if_addr;
    word_mis    = rom_address[WAS-1:0] != '0;
    word        = word_mis ? '0 : rom_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q   <= OWN_NONE;
      starve_q  <= '0;
      if_data_q <= '0;
      if_mis_q  <= 1'b0;
      d_data_q  <= '0;
      d_mis_q   <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      if_data_q <= if_data_d;
      if_mis_q  <= if_mis_d;
      d_data_q  <= d_data_d;
      d_mis_q   <= d_mis_d;
    end
  end

  // Next owner follows the grant; starvation count freezes during flush
  always_comb begin
    owner_d   = OWN_NONE;
    starve_d  = starve_q;
    if_data_d = if_data_q;
    if_mis_d  = if_mis_q;
    d_data_d  = d_data_q;
    d_mis_d   = d_mis_q;
    if (grant_i) begin
      owner_d   = OWN_I;
      if_data_d = word;
      if_mis_d  = word_mis;
    end else if (grant_d) begin
      owner_d   = OWN_D;
      d_data_d  = word;
      d_mis_d   = word_mis;
    end
    if (grant_i || !if_valid) begin
      starve_d = '0;
    end else if (!flush && starve_q < SW'(MAX_WAIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // A flush discards a fetch response that is on its way out
  always_comb begin
    if_ready           = grant_i;
    d_ready            = grant_d;
    if_resp_valid      = (owner_q == OWN_I) && !flush;
    d_resp_valid       = (owner_q == OWN_D);
    if_resp_data       = if_data_q;
    if_resp_misaligned = if_mis_q;
    d_resp_data        = d_data_q;
    d_resp_misaligned  = d_mis_q;
  end

`ifdef ROM_ARB_STATS_EN
  logic [31:0] st_i_q, st_i_d, st_d_q, st_d_d, st_c_q, st_c_d;

  always_comb begin
    st_i_d = st_i_q + 32'(grant_i);
    st_d_d = st_d_q + 32'(grant_d);
    st_c_d = st_c_q + 32'(if_valid && d_valid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_i_q <= '0;
      st_d_q <= '0;
      st_c_q <= '0;
    end else begin
      st_i_q <= st_i_d;
      st_d_q <= st_d_d;
      st_c_q <= st_c_d;
    end
  end

  assign stat_if_grants = st_i_q;
  assign stat_d_grants  = st_d_q;
  assign stat_conflicts = st_c_q;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: vector table, directed corner sequences and
// randomized traffic against a rule-level reference model.

module tb_rom_port_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_valid, d_valid, flush;
  logic [AW-1:0] if_addr, d_addr, rom_address;
  logic          if_ready, d_ready;
  logic          if_resp_valid, d_resp_valid;
  logic [DW-1:0] if_resp_data, d_resp_data, rom_data;
  logic          if_resp_misaligned, d_resp_misaligned;
`ifdef ROM_ARB_STATS_EN
  logic [31:0]   stat_if_grants, stat_d_grants, stat_conflicts;
`endif

  logic [DW-1:0] rom_mem [64];
  assign rom_data = rom_mem[rom_address[AW-1:2]];

  rom_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .if_resp_misaligned(if_resp_misaligned),
    .d_valid(d_valid), .d_addr(d_addr), .d_ready(d_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .d_resp_misaligned(d_resp_misaligned),
    .flush(flush), .rom_address(rom_address), .rom_data(rom_data)
`ifdef ROM_ARB_STATS_EN
    , .stat_if_grants(stat_if_grants), .stat_d_grants(stat_d_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: refusals-in-a-row count, side whose response is due, last word per side
  int            m_starve;
  int            m_pend;
  logic [DW-1:0] m_idata, m_ddata;
  logic          m_imis, m_dmis;

  typedef struct {
    logic          iv;
    logic [AW-1:0] ia;
    logic          dv;
    logic [AW-1:0] da;
    logic          fl;
    logic          ir;
    logic          dr;
    logic [AW-1:0] addr;
    logic          irv;
    logic          drv;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    m_pend   = 0;
    m_idata  = '0;
    m_ddata  = '0;
    m_imis   = 1'b0;
    m_dmis   = 1'b0;
  endtask

  task automatic do_cycle(input logic iv, input logic [AW-1:0] ia, input logic dv,
                          input logic [AW-1:0] da, input logic fl,
                          output logic ir, output logic dr, output logic [AW-1:0] addr,
                          output logic irv, output logic drv);
    logic          gi, gd, mis;
    logic [AW-1:0] wa;
    logic [DW-1:0] w;
    @(negedge clk);
    if_valid = iv; if_addr = ia; d_valid = dv; d_addr = da; flush = fl;
    gi = iv && !fl && (!dv || m_starve >= int'(MW));
    gd = dv && !gi;
    #4;
    ir = if_ready; dr = d_ready; addr = rom_address;
    irv = if_resp_valid; drv = d_resp_valid;
    chk("if_ready", DW'(if_ready), DW'(gi));
    chk("d_ready", DW'(d_ready), DW'(gd));
    chk("rom_address", DW'(rom_address), DW'(gd ? da : ia));
    chk("if_resp_valid", DW'(if_resp_valid), DW'(m_pend == 1 && !fl));
    chk("d_resp_valid", DW'(d_resp_valid), DW'(m_pend == 2));
    chk("if_resp_data", if_resp_data, m_idata);
    chk("if_resp_mis", DW'(if_resp_misaligned), DW'(m_imis));
    chk("d_resp_data", d_resp_data, m_ddata);
    chk("d_resp_mis", DW'(d_resp_misaligned), DW'(m_dmis));
    @(posedge clk);
    wa  = gi ? ia : da;
    mis = (wa % 4) != 0;
    w   = mis ? '0 : rom_mem[wa / 4];
    if (gi) begin m_idata = w; m_imis = mis; end
    if (gd) begin m_ddata = w; m_dmis = mis; end
    m_pend = gi ? 1 : (gd ? 2 : 0);
    if (gi || !iv) m_starve = 0;
    else if (!fl) m_starve = (m_starve + 1 > int'(MW)) ? int'(MW) : m_starve + 1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; if_valid = 1'b1; d_valid = 1'b1; flush = 1'b0;
    #2;
    chk("rst_if_ready", DW'(if_ready), '0);
    chk("rst_d_ready", DW'(d_ready), '0);
    chk("rst_resp_valid", DW'({if_resp_valid, d_resp_valid}), '0);
    chk("rst_resp_mis", DW'({if_resp_misaligned, d_resp_misaligned}), '0);
    chk("rst_if_data", if_resp_data, '0);
    chk("rst_d_data", d_resp_data, '0);
    @(negedge clk);
    reset = 1'b0; if_valid = 1'b0; d_valid = 1'b0;
    model_reset();
  endtask

  logic          ir, dr, irv, drv, riv, rdv, rfl, last_ir, last_dr;
  logic [AW-1:0] addr, ria, rda;

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] a;
    a = AW'($urandom);
    if ($urandom_range(3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    reset = 1'b0; if_valid = 1'b0; d_valid = 1'b0; flush = 1'b0;
    if_addr = '0; d_addr = '0;
    for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
    model_reset();

    tbl[0] = '{1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'h20, 1'b1, 8'h30, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'h24, 1'b1, 8'h30, 1'b1, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h24, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 8'h24, 1'b0, 1'b1};

    #1;
    apply_reset();

    // First fetch after reset: accepted at once, word 0 returned next cycle
    do_cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, ir, dr, addr, irv, drv);
    chk("first_fetch_ready", DW'(ir), 32'd1);
    do_cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, ir, dr, addr, irv, drv);
    chk("first_fetch_resp", DW'(irv), 32'd1);
    #1;
    chk("first_fetch_data", if_resp_data, rom_mem[0]);

    for (int i = 0; i < 8; i++) begin
      do_cycle(tbl[i].iv, tbl[i].ia, tbl[i].dv, tbl[i].da, tbl[i].fl, ir, dr, addr, irv, drv);
      chk($sformatf("tbl%0d_if_ready", i), DW'(ir), DW'(tbl[i].ir));
      chk($sformatf("tbl%0d_d_ready", i), DW'(dr), DW'(tbl[i].dr));
      chk($sformatf("tbl%0d_addr", i), DW'(addr), DW'(tbl[i].addr));
      chk($sformatf("tbl%0d_if_resp_valid", i), DW'(irv), DW'(tbl[i].irv));
      chk($sformatf("tbl%0d_d_resp_valid", i), DW'(drv), DW'(tbl[i].drv));
    end

    // Misaligned data load returns zero with the misaligned flag
    do_cycle(1'b0, 8'h00, 1'b1, 8'h06, 1'b0, ir, dr, addr, irv, drv);
    do_cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, ir, dr, addr, irv, drv);
    chk("mis_resp_valid", DW'(drv), 32'd1);
    #1;
    chk("mis_data", d_resp_data, '0);
    chk("mis_flag", DW'(d_resp_misaligned), 32'd1);

    // Reset in the middle of a pending data response
    do_cycle(1'b0, 8'h00, 1'b1, 8'h08, 1'b0, ir, dr, addr, irv, drv);
    @(negedge clk);
    if_valid = 1'b0; d_valid = 1'b0;
    #1;
    chk("midrst_pre_valid", DW'(d_resp_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_valid", DW'(d_resp_valid), '0);
    chk("midrst_d_data", d_resp_data, '0);
    chk("midrst_d_mis", DW'(d_resp_misaligned), '0);
    chk("midrst_ready", DW'({if_ready, d_ready}), '0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, ir, dr, addr, irv, drv);
    chk("midrst_no_resp", DW'({irv, drv}), '0);

    // Randomized traffic; requesters keep valid and address until accepted
    riv = 1'b0; rdv = 1'b0; ria = '0; rda = '0; last_ir = 1'b0; last_dr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!(riv && !last_ir)) begin
        riv = $urandom_range(2) != 0;
        ria = rnd_addr();
      end
      if (!(rdv && !last_dr)) begin
        rdv = $urandom_range(2) != 0;
        rda = rnd_addr();
      end
      rfl = $urandom_range(7) == 0;
      do_cycle(riv, ria, rdv, rda, rfl, ir, dr, addr, irv, drv);
      last_ir = ir;
      last_dr = dr;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
